// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered, handshaked ALU control decoder with MUL/DIV pacing
//
// Ports:
//   clk        in   1     rising-edge clock
//   reset      in   1     synchronous active-high reset
//   in_valid   in   1     request valid
//   in_ready   out  1     request can be accepted this cycle
//   alu_op     in   2     ALUOp from main control
//   funct      in   4     {funct7[5], funct3}
//   m_ext      in   1     funct7 == 0000001
//   out_valid  out  1     operation/illegal valid
//   out_ready  in   1     consumer accepts output
//   operation  out  OP_W  ALU operation code (bits above 3 are zero)
//   illegal    out  1     request had no legal decode
//   busy       out  1     multi-cycle operation in progress

module alu_control_seq #(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [3:0]      funct,
  input  logic            m_ext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] operation,
  output logic            illegal,
  output logic            busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       op_q, op_next;
  logic             illegal_q, illegal_next;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       dec_op;
  logic             dec_illegal;
  logic             dec_multi;
  logic [CNT_W-1:0] dec_load;
  logic             accept;

  // Request decode; dec_load is the counter preload (LAT-1) for multi-cycle ops.
  always_comb begin
    dec_op      = 4'b0000;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    dec_load    = '0;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        case (funct[2:0])
          3'b000:  dec_op = OP_SUB;
          3'b100:  dec_op = OP_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (!m_ext) begin
          case (funct)
            4'b0000: dec_op = OP_ADD;
            4'b1000: dec_op = OP_SUB;
            4'b0111: dec_op = OP_AND;
            4'b0110: dec_op = OP_OR;
            4'b0100: dec_op = OP_XOR;
            default: dec_illegal = 1'b1;
          endcase
        end else begin
          case (funct[2:0])
            3'b000: begin
              dec_op    = OP_MUL;
              dec_multi = 1'b1;
              dec_load  = CNT_W'(MUL_LAT - 1);
            end
            3'b100: begin
              dec_op    = OP_DIV;
              dec_multi = 1'b1;
              dec_load  = CNT_W'(DIV_LAT - 1);
            end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // In DONE the slot frees up in the same cycle the consumer takes the result.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    op_next      = op_q;
    illegal_next = illegal_q;

    case (state)
      EXEC: begin
        // Leave EXEC on the edge where the counter reaches zero.
        if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or from DONE while draining, and in
    // both cases the new request is launched exactly as from IDLE.
    if (accept) begin
      op_next      = dec_op;
      illegal_next = dec_illegal;
      cnt_next     = dec_load;
      state_next   = (dec_multi && (dec_load != '0)) ? EXEC : DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= 4'b0000;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      op_q        <= op_next;
      illegal_q   <= illegal_next;
      out_valid_q <= (state_next == DONE);
      busy_q      <= (state_next == EXEC);
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;
  assign operation = OP_W'(op_q);

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq

module tb_alu_control_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [3:0] funct;
  logic       m_ext;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] operation;
  logic       illegal;
  logic       busy;

  int checks;
  int errors;

  alu_control_seq #(
    .OP_W(4),
    .MUL_LAT(3),
    .DIV_LAT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_op(alu_op),
    .funct(funct),
    .m_ext(m_ext),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .operation(operation),
    .illegal(illegal),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [3:0] f, input logic m);
    in_valid = v;
    alu_op   = a;
    funct    = f;
    m_ext    = m;
  endtask

  // {alu_op, m_ext, funct, expected operation, expected illegal}
  logic [11:0] vec [11];

  initial begin
    vec[0]  = {2'b00, 1'b0, 4'b0000, 4'b0010, 1'b0};
    vec[1]  = {2'b01, 1'b0, 4'b1000, 4'b0110, 1'b0};
    vec[2]  = {2'b10, 1'b0, 4'b0000, 4'b0010, 1'b0};
    vec[3]  = {2'b10, 1'b0, 4'b1000, 4'b0110, 1'b0};
    vec[4]  = {2'b10, 1'b0, 4'b0111, 4'b0000, 1'b0};
    vec[5]  = {2'b10, 1'b0, 4'b0110, 4'b0001, 1'b0};
    vec[6]  = {2'b10, 1'b0, 4'b0100, 4'b0011, 1'b0};
    vec[7]  = {2'b10, 1'b0, 4'b0001, 4'b0000, 1'b1};
    vec[8]  = {2'b10, 1'b1, 4'b0001, 4'b0000, 1'b1};
    vec[9]  = {2'b11, 1'b1, 4'b0000, 4'b0000, 1'b1};
    vec[10] = {2'b01, 1'b1, 4'b0000, 4'b0110, 1'b0};

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal, 0);
    check("rst_operation", operation, 0);
    check("rst_in_ready", in_ready, 1);

    // ADD, latency 1, then drop
    drive(1'b1, 2'b00, 4'b0000, 1'b0);
    step();
    check("add_valid", out_valid, 1);
    check("add_op", operation, 4'b0010);
    check("add_illegal", illegal, 0);
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    step();
    check("add_drop", out_valid, 0);

    // Back-to-back SLT, OR, illegal
    drive(1'b1, 2'b01, 4'b1100, 1'b0);
    step();
    check("slt_valid", out_valid, 1);
    check("slt_op", operation, 4'b0100);
    drive(1'b1, 2'b10, 4'b0110, 1'b0);
    #1;
    check("b2b_in_ready", in_ready, 1);
    step();
    check("or_valid", out_valid, 1);
    check("or_op", operation, 4'b0001);
    drive(1'b1, 2'b01, 4'b1010, 1'b0);
    step();
    check("ill01_valid", out_valid, 1);
    check("ill01_illegal", illegal, 1);
    check("ill01_op", operation, 0);
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    step();
    check("b2b_drop", out_valid, 0);

    // DIV with a held ADD request behind it
    drive(1'b1, 2'b10, 4'b0100, 1'b1);
    step();
    drive(1'b1, 2'b00, 4'b0000, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("div_busy_%0d", i), busy, 1);
      check($sformatf("div_in_ready_%0d", i), in_ready, 0);
      check($sformatf("div_valid_%0d", i), out_valid, 0);
      step();
    end
    check("div_valid", out_valid, 1);
    check("div_op", operation, 4'b1001);
    check("div_busy_end", busy, 0);
    step();
    check("held_add_valid", out_valid, 1);
    check("held_add_op", operation, 4'b0010);
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    step();
    check("div_drop", out_valid, 0);

    // MUL with consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 4'b1000, 1'b1);
    step();
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    check("mul_busy1", busy, 1);
    step();
    check("mul_busy2", busy, 1);
    check("mul_valid2", out_valid, 0);
    step();
    check("mul_valid", out_valid, 1);
    check("mul_op", operation, 4'b1000);
    check("mul_stall_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mul_hold_valid_%0d", i), out_valid, 1);
      check($sformatf("mul_hold_op_%0d", i), operation, 4'b1000);
    end
    out_ready = 1'b1;
    step();
    check("mul_release_valid", out_valid, 0);
    check("mul_release_in_ready", in_ready, 1);

    // Reset two cycles into a DIV
    drive(1'b1, 2'b10, 4'b0100, 1'b1);
    step();
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    step();
    check("rdiv_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rdiv_valid", out_valid, 0);
    check("rdiv_busy_clr", busy, 0);
    check("rdiv_op", operation, 0);
    check("rdiv_in_ready", in_ready, 1);
    drive(1'b1, 2'b00, 4'b0000, 1'b0);
    step();
    check("rdiv_add_valid", out_valid, 1);
    check("rdiv_add_op", operation, 4'b0010);

    // Reset wins over a simultaneous accept
    reset = 1'b1;
    drive(1'b1, 2'b00, 4'b0000, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    check("rprio_valid", out_valid, 0);
    step();
    check("rprio_valid2", out_valid, 0);

    // Single-cycle decode table, streamed back-to-back
    for (int i = 0; i < 11; i++) begin
      logic [11:0] v;
      v = vec[i];
      drive(1'b1, v[11:10], v[8:5], v[9]);
      step();
      check($sformatf("tbl%0d_valid", i), out_valid, 1);
      check($sformatf("tbl%0d_op", i), operation, v[4:1]);
      check($sformatf("tbl%0d_illegal", i), illegal, v[0]);
    end
    drive(1'b0, 2'b00, 4'b0000, 1'b0);
    step();
    check("tbl_drop", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
